imem_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the CPU's instruction memory.
- Receives a byte stream (from a UART receiver or testbench) framed as: length, data words, checksum.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU in reset until a complete, checksum-valid image has been written.

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: receives a length/data/checksum byte stream, writes little-endian
// 32-bit words into instruction memory, and holds the CPU in reset until the image verifies.
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH_WORDS);

    state_t      state, next_state;
    logic [15:0] len;
    logic [15:0] word_index;
    logic [1:0]  lane;
    logic [7:0]  csum;
    logic [23:0] word_buf;
    logic        accept;
    logic [15:0] len_full;
    logic        len_ok;
    logic        word_last;

    // Reset is folded in so the loader refuses bytes while held in reset.
    assign byte_ready = reset && (state == LEN0 || state == LEN1 ||
                                  state == DATA || state == CSUM);
    assign accept     = byte_valid && byte_ready && !reload;
    assign len_full   = {byte_data, len[7:0]};
    assign len_ok     = (len_full != 16'd0) && (len_full <= DEPTH_LIMIT);
    assign word_last  = (lane == 2'd3) && (word_index == len - 16'd1);

    always_comb begin
        next_state = state;
        if (reload) begin
            next_state = LEN0;
        end else if (accept) begin
            case (state)
                LEN0:    next_state = LEN1;
                LEN1:    next_state = len_ok ? DATA : ERR;
                DATA:    if (word_last) next_state = CSUM;
                CSUM:    next_state = (byte_data == csum) ? DONE : ERR;
                default: next_state = state;
            endcase
        end
    end

    // Status outputs are registered from next_state so they align with the state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LEN0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
        end else begin
            state       <= next_state;
            done        <= (next_state == DONE);
            error       <= (next_state == ERR);
            cpu_reset_n <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            word_index <= '0;
            lane       <= '0;
            csum       <= '0;
            word_buf   <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
        end else begin
            im_we <= 1'b0;
            if (reload) begin
                len        <= '0;
                word_index <= '0;
                lane       <= '0;
                csum       <= '0;
                word_buf   <= '0;
            end else if (accept) begin
                case (state)
                    LEN0: len[7:0]  <= byte_data;
                    LEN1: len[15:8] <= byte_data;
                    DATA: begin
                        csum <= csum ^ byte_data;
                        if (lane == 2'd3) begin
                            im_we      <= 1'b1;
                            im_wdata   <= {byte_data, word_buf};
                            im_addr    <= ADDR_W'({word_index, 2'b00});
                            word_index <= word_index + 16'd1;
                            lane       <= 2'd0;
                        end else begin
                            word_buf[8*lane +: 8] <= byte_data;
                            lane                  <= lane + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good/bad checksum, length limits,
// gapped stream, reload mid-load and asynchronous reset out of DONE.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    int          wr_count = 0;
    int          wr_base;
    logic [7:0]  img [$];

    imem_loader #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .reload      (reload),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .cpu_reset_n (cpu_reset_n),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Capture every memory write on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (wr_count < 32) begin
                wr_addr[wr_count] = im_addr;
                wr_data[wr_count] = im_wdata;
            end
            wr_count = wr_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_image(input int max_gap);
        foreach (img[i]) applyStimulus(img[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1)));
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload     = 1'b0;

        #1;
        checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst_im_we", 32'(im_we), 32'd0);
        checkOutput("rst_im_addr", im_addr, 32'd0);
        checkOutput("rst_im_wdata", im_wdata, 32'd0);
        checkOutput("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        #21 reset = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(byte_ready), 32'd1);

        // Two-word image; XOR of 13 05 10 00 93 05 20 00 is 0xB0.
        wr_base = wr_count;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        send_image(0);
        checkOutput("good_done", 32'(done), 32'd1);
        checkOutput("good_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        checkOutput("good_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("good_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("good_wr_count", 32'(wr_count - wr_base), 32'd2);
        checkOutput("good_wr0_addr", wr_addr[wr_base], 32'h0);
        checkOutput("good_wr0_data", wr_data[wr_base], 32'h00100513);
        checkOutput("good_wr1_addr", wr_addr[wr_base+1], 32'h4);
        checkOutput("good_wr1_data", wr_data[wr_base+1], 32'h00200593);

        pulse_reload();
        checkOutput("reload_done", 32'(done), 32'd0);
        checkOutput("reload_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("reload_ready", 32'(byte_ready), 32'd1);

        // Same image, wrong checksum.
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'h95};
        send_image(0);
        checkOutput("badcs_error", 32'(error), 32'd1);
        checkOutput("badcs_done", 32'(done), 32'd0);
        checkOutput("badcs_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("badcs_ready", 32'(byte_ready), 32'd0);

        // Zero length and over-capacity length.
        pulse_reload();
        wr_base = wr_count;
        img = '{8'h00, 8'h00};
        send_image(0);
        checkOutput("len0_error", 32'(error), 32'd1);
        checkOutput("len0_ready", 32'(byte_ready), 32'd0);
        pulse_reload();
        img = '{8'h01, 8'h01};
        send_image(0);
        checkOutput("len257_error", 32'(error), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("badlen_no_writes", 32'(wr_count - wr_base), 32'd0);

        // One word with random gaps; EF^BE^AD^DE = 0x22.
        pulse_reload();
        wr_base = wr_count;
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_image(4);
        checkOutput("gap_done", 32'(done), 32'd1);
        checkOutput("gap_wr_count", 32'(wr_count - wr_base), 32'd1);
        checkOutput("gap_wr_addr", wr_addr[wr_base], 32'h0);
        checkOutput("gap_wr_data", wr_data[wr_base], 32'hDEADBEEF);

        // Reload halfway through word 2 of a 3-word load, then a 1-word image (csum 0x08).
        pulse_reload();
        wr_base = wr_count;
        img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_image(0);
        pulse_reload();
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_image(0);
        checkOutput("reld_done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("reld_wr_count", 32'(wr_count - wr_base), 32'd2);
        checkOutput("reld_wr0_data", wr_data[wr_base], 32'h44332211);
        checkOutput("reld_wr1_addr", wr_addr[wr_base+1], 32'h0);
        checkOutput("reld_wr1_data", wr_data[wr_base+1], 32'h12345678);

        // Asynchronous reset out of DONE, between clock edges.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        checkOutput("async_ready", 32'(byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_release_ready", 32'(byte_ready), 32'd1);
        wr_base = wr_count;
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_image(0);
        checkOutput("after_rst_done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("after_rst_wr_addr", wr_addr[wr_base], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
